// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module   : mux_scan_pkg
// Purpose  : Shared mode/state encodings and constant helpers for mux_scan.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [0:0] {
        S_MANUAL = 1'b0,
        S_SCAN   = 1'b1
    } state_t;

    // Smallest r with 2**r >= v; used to size counters from parameters.
    function automatic int clog2(input longint unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_cnt.sv
// ============================================================================
// Module   : scan_cnt
// Purpose  : Dwell counter 0..DWELL with clear, hold and terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_cnt
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 24_999_999
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_hold,
    output logic o_tc
);

    localparam int CNT_W = clog2(longint'(DWELL) + 1);
    localparam logic [CNT_W-1:0] c_dwell = CNT_W'(DWELL);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == c_dwell);

    // Clear has priority so mode changes always restart a full dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            if (w_tc) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_tc = w_tc;

endmodule

`default_nettype wire

// File: rtl/mux_scan.sv
// ============================================================================
// Module   : mux_scan
// Purpose  : N-channel registered mux with manual select and auto-scan mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int          WIDTH  = 8,
    parameter int          CH_NUM = 4,
    parameter int          SEL_W  = 2,
    parameter int unsigned DWELL  = 24_999_999
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [CH_NUM*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    input  logic                    hold,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    ch_switch,
    output logic                    sel_err
);

    localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(CH_NUM - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_clr;
    logic               w_tc;
    logic [SEL_W-1:0]   w_ch_nxt;
    logic               w_sel_err;
    logic [WIDTH-1:0]   w_data;
    logic [WIDTH-1:0]   r_data;
    logic [SEL_W-1:0]   r_ch;
    logic               r_switch;
    logic               r_sel_err;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_MANUAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_MANUAL: if (mode == MODE_SCAN)   w_state_nxt = S_SCAN;
            S_SCAN:   if (mode == MODE_MANUAL) w_state_nxt = S_MANUAL;
            default:  w_state_nxt = S_MANUAL;
        endcase
    end

    // Counter sits at zero outside SCAN and on every mode change.
    assign w_clr = (r_state != S_SCAN) || (w_state_nxt != S_SCAN);

    scan_cnt #(
        .DWELL (DWELL)
    ) u_scan_cnt (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .i_clr  (w_clr),
        .i_hold (hold),
        .o_tc   (w_tc)
    );

    // Channel decision uses the next state so a return to MANUAL follows sel at once.
    always_comb begin
        w_ch_nxt  = r_ch;
        w_sel_err = 1'b0;
        if (w_state_nxt == S_MANUAL) begin
            if (32'(sel) < CH_NUM) begin
                w_ch_nxt = sel;
            end else begin
                w_ch_nxt  = '0;
                w_sel_err = 1'b1;
            end
        end else if ((r_state == S_SCAN) && w_tc && !hold) begin
            w_ch_nxt = (r_ch == c_last_ch) ? '0 : r_ch + SEL_W'(1);
        end
    end

    always_comb begin
        w_data = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (w_ch_nxt == SEL_W'(k)) begin
                w_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_data    <= '0;
            r_ch      <= '0;
            r_switch  <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_data    <= w_data;
            r_ch      <= w_ch_nxt;
            r_switch  <= (w_ch_nxt != r_ch);
            r_sel_err <= w_sel_err;
        end
    end

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign ch_switch = r_switch;
    assign sel_err   = r_sel_err;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan.sv
// ============================================================================
// Module   : tb_mux_scan
// Purpose  : Directed self-checking bench for mux_scan (3 channels, DWELL=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_scan;

    localparam int WIDTH  = 8;
    localparam int CH_NUM = 3;
    localparam int SEL_W  = 2;
    localparam int DWELL  = 3;

    logic                    sys_clk;
    logic                    sys_rst_n;
    logic [CH_NUM*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    mode;
    logic                    hold;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    ch_switch;
    logic                    sel_err;

    int n_checks;
    int n_errors;

    mux_scan #(
        .WIDTH  (WIDTH),
        .CH_NUM (CH_NUM),
        .SEL_W  (SEL_W),
        .DWELL  (DWELL)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_data   (in_data),
        .sel       (sel),
        .mode      (mode),
        .hold      (hold),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .ch_switch (ch_switch),
        .sel_err   (sel_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge for sampling/driving.
    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic [1:0] ch,
                             input logic sw, input logic err);
        check({tag, ".data"}, 32'(out_data), 32'(d));
        check({tag, ".ch"},   32'(out_ch),   32'(ch));
        check({tag, ".sw"},   32'(ch_switch), 32'(sw));
        check({tag, ".err"},  32'(sel_err),  32'(err));
    endtask

    logic [7:0] ch_val [3];
    logic [1:0] exp_ch;
    logic       exp_sw;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        ch_val[0] = 8'hA0;
        ch_val[1] = 8'hB1;
        ch_val[2] = 8'hC2;
        sys_rst_n = 1'b0;
        in_data   = {8'hC2, 8'hB1, 8'hA0};
        sel       = 2'd0;
        mode      = 1'b0;
        hold      = 1'b0;

        step();
        step();
        check_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);

        sys_rst_n = 1'b1;
        step();
        check_out("man_sel0", 8'hA0, 2'd0, 1'b0, 1'b0);

        sel = 2'd1;
        step();
        check_out("man_sel1", 8'hB1, 2'd1, 1'b1, 1'b0);
        step();
        check_out("man_sel1_hold", 8'hB1, 2'd1, 1'b0, 1'b0);

        sel = 2'd3;
        step();
        check_out("man_sel3", 8'hA0, 2'd0, 1'b1, 1'b1);

        sel = 2'd2;
        step();
        check_out("man_sel2", 8'hC2, 2'd2, 1'b1, 1'b0);

        // Scan from channel 2: four cycles on 2, then 0,1,2,0 every 4 cycles.
        mode = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n <= 4) begin
                exp_ch = 2'd2;
                exp_sw = 1'b0;
            end else begin
                exp_ch = 2'(((n - 5) / 4) % 3);
                exp_sw = ((n - 5) % 4) == 0;
            end
            check_out($sformatf("scan_n%0d", n), ch_val[exp_ch], exp_ch, exp_sw, 1'b0);
        end

        // Counter now at terminal count on channel 0; hold must win.
        hold = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            check_out($sformatf("hold_%0d", n), 8'hA0, 2'd0, 1'b0, 1'b0);
        end
        hold = 1'b0;
        step();
        check_out("hold_release", 8'hB1, 2'd1, 1'b1, 1'b0);

        in_data = {8'hC2, 8'h5F, 8'hA0};
        step();
        check_out("data_track", 8'h5F, 2'd1, 1'b0, 1'b0);
        step();
        check_out("dwell_c2", 8'h5F, 2'd1, 1'b0, 1'b0);
        step();
        check_out("dwell_c3", 8'h5F, 2'd1, 1'b0, 1'b0);
        step();
        check_out("dwell_adv", 8'hC2, 2'd2, 1'b1, 1'b0);

        // Asynchronous reset between edges.
        #2;
        sys_rst_n = 1'b0;
        mode      = 1'b0;
        sel       = 2'd1;
        #1;
        check_out("async_rst", 8'h00, 2'd0, 1'b0, 1'b0);
        step();
        check_out("rst_held", 8'h00, 2'd0, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        step();
        check_out("post_rst", 8'h5F, 2'd1, 1'b1, 1'b0);
        sel = 2'd0;
        step();
        check_out("post_rst_sel0", 8'hA0, 2'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
